// File: rtl/hwpe_ctrl_reqrsp_offloader.sv
// rtl/hwpe_ctrl_reqrsp_offloader.sv - offloads one job to an HWPE register target over reqrsp
module hwpe_ctrl_reqrsp_offloader #(
    parameter int AW         = 32,
    parameter int DW         = 64,
    parameter int N_ARGS_MAX = 16,
    parameter int POLL_GAP   = 4,
    localparam int NW        = $clog2(N_ARGS_MAX + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    // job command
    input  logic            job_valid_i,
    output logic            job_ready_o,
    input  logic [NW-1:0]   job_nargs_i,
    input  logic            job_wait_i,
    // argument stream
    input  logic            arg_valid_i,
    output logic            arg_ready_o,
    input  logic [DW-1:0]   arg_data_i,
    // reqrsp request
    output logic [AW-1:0]   q_addr_o,
    output logic            q_write_o,
    output logic [DW-1:0]   q_data_o,
    output logic [DW/8-1:0] q_strb_o,
    output logic            q_valid_o,
    input  logic            q_ready_i,
    // reqrsp read response
    input  logic [DW-1:0]   p_data_i,
    input  logic            p_valid_i,
    output logic            p_ready_o,
    // completion report
    output logic            done_valid_o,
    input  logic            done_ready_i,
    output logic [7:0]      done_jobid_o,
    output logic            busy_o
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ACQ_REQ   = 4'd1;
    localparam logic [3:0] S_ACQ_RSP   = 4'd2;
    localparam logic [3:0] S_ACQ_GAP   = 4'd3;
    localparam logic [3:0] S_PUSH_ARG  = 4'd4;
    localparam logic [3:0] S_PUSH_REQ  = 4'd5;
    localparam logic [3:0] S_TRIG_REQ  = 4'd6;
    localparam logic [3:0] S_JOBID_REQ = 4'd7;
    localparam logic [3:0] S_JOBID_RSP = 4'd8;
    localparam logic [3:0] S_POLL_GAP  = 4'd9;
    localparam logic [3:0] S_POLL_REQ  = 4'd10;
    localparam logic [3:0] S_POLL_RSP  = 4'd11;
    localparam logic [3:0] S_REPORT    = 4'd12;

    // Register map of the target: byte address = register index << 3.
    localparam logic [AW-1:0] ADDR_TRIGGER = AW'(8'h00);
    localparam logic [AW-1:0] ADDR_STATUS  = AW'(8'h08);
    localparam logic [AW-1:0] ADDR_JOBID   = AW'(8'h10);
    localparam logic [AW-1:0] ADDR_PUSH    = AW'(8'h20);

    localparam int            GW         = $clog2(POLL_GAP + 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(POLL_GAP - 1);
    localparam logic [NW-1:0] NARGS_MAX  = NW'(N_ARGS_MAX);

    logic [3:0]      r_state;
    logic [NW-1:0]   r_nargs;
    logic            r_wait;
    logic [GW-1:0]   r_gap_cnt;
    logic [DW-1:0]   r_arg_data;
    logic [7:0]      r_jobid;
    logic [AW-1:0]   r_q_addr;
    logic            r_q_write;
    logic [DW-1:0]   r_q_data;
    logic [DW/8-1:0] r_q_strb;
    logic            r_q_valid;

    logic [AW-1:0]   w_req_addr;
    logic            w_req_write;
    logic [DW-1:0]   w_req_data;
    logic [3:0]      w_req_next;
    logic [NW-1:0]   w_nargs_sat;
    logic            w_p_fire;
    logic            w_arg_fire;
    logic            w_status_idle;

    // Handshake-side outputs are pure functions of the state.
    always_comb begin
        job_ready_o  = (r_state == S_IDLE);
        busy_o       = (r_state != S_IDLE);
        arg_ready_o  = (r_state == S_PUSH_ARG);
        p_ready_o    = (r_state == S_ACQ_RSP) || (r_state == S_JOBID_RSP) ||
                       (r_state == S_POLL_RSP);
        done_valid_o = (r_state == S_REPORT);
    end

    assign q_addr_o     = r_q_addr;
    assign q_write_o    = r_q_write;
    assign q_data_o     = r_q_data;
    assign q_strb_o     = r_q_strb;
    assign q_valid_o    = r_q_valid;
    assign done_jobid_o = r_jobid;

    assign w_p_fire      = p_valid_i && p_ready_o;
    assign w_arg_fire    = arg_valid_i && arg_ready_o;
    assign w_status_idle = (p_data_i == '0);
    assign w_nargs_sat   = (job_nargs_i > NARGS_MAX) ? NARGS_MAX : job_nargs_i;

    // Request contents and the state that follows acceptance, per request state.
    always_comb begin
        w_req_addr  = '0;
        w_req_write = 1'b0;
        w_req_data  = '0;
        w_req_next  = S_IDLE;
        case (r_state)
            S_ACQ_REQ: begin
                w_req_addr = ADDR_STATUS;
                w_req_next = S_ACQ_RSP;
            end
            S_PUSH_REQ: begin
                w_req_addr  = ADDR_PUSH;
                w_req_write = 1'b1;
                w_req_data  = r_arg_data;
                w_req_next  = (r_nargs == '0) ? S_TRIG_REQ : S_PUSH_ARG;
            end
            S_TRIG_REQ: begin
                w_req_addr  = ADDR_TRIGGER;
                w_req_write = 1'b1;
                w_req_next  = S_JOBID_REQ;
            end
            S_JOBID_REQ: begin
                w_req_addr = ADDR_JOBID;
                w_req_next = S_JOBID_RSP;
            end
            S_POLL_REQ: begin
                w_req_addr = ADDR_STATUS;
                w_req_next = S_POLL_RSP;
            end
            default: begin
                w_req_next = S_IDLE;
            end
        endcase
    end

    // Job sequencer: one outstanding request, registered and held until accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state    <= S_IDLE;
            r_nargs    <= '0;
            r_wait     <= 1'b0;
            r_gap_cnt  <= '0;
            r_arg_data <= '0;
            r_jobid    <= '0;
            r_q_addr   <= '0;
            r_q_write  <= 1'b0;
            r_q_data   <= '0;
            r_q_strb   <= '0;
            r_q_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (job_valid_i) begin
                        r_nargs <= w_nargs_sat;
                        r_wait  <= job_wait_i;
                        r_state <= S_ACQ_REQ;
                    end
                end
                S_ACQ_REQ, S_PUSH_REQ, S_TRIG_REQ, S_JOBID_REQ, S_POLL_REQ: begin
                    // First cycle in the state launches the request; the
                    // fields then stay frozen until the target takes it.
                    if (!r_q_valid) begin
                        r_q_addr  <= w_req_addr;
                        r_q_write <= w_req_write;
                        r_q_data  <= w_req_data;
                        r_q_strb  <= {(DW/8){w_req_write}};
                        r_q_valid <= 1'b1;
                    end else if (q_ready_i) begin
                        r_q_valid <= 1'b0;
                        r_state   <= w_req_next;
                    end
                end
                S_ACQ_RSP: begin
                    if (w_p_fire) begin
                        if (!w_status_idle) begin
                            r_gap_cnt <= '0;
                            r_state   <= S_ACQ_GAP;
                        end else if (r_nargs == '0) begin
                            r_state <= S_TRIG_REQ;
                        end else begin
                            r_state <= S_PUSH_ARG;
                        end
                    end
                end
                S_ACQ_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_ACQ_REQ;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                S_PUSH_ARG: begin
                    if (w_arg_fire) begin
                        r_arg_data <= arg_data_i;
                        if (r_nargs != '0) begin
                            r_nargs <= r_nargs - NW'(1);
                        end
                        r_state <= S_PUSH_REQ;
                    end
                end
                S_JOBID_RSP: begin
                    if (w_p_fire) begin
                        r_jobid <= p_data_i[7:0];
                        if (r_wait) begin
                            r_gap_cnt <= '0;
                            r_state   <= S_POLL_GAP;
                        end else begin
                            r_state <= S_REPORT;
                        end
                    end
                end
                S_POLL_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_POLL_REQ;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                S_POLL_RSP: begin
                    if (w_p_fire) begin
                        if (w_status_idle) begin
                            r_state <= S_REPORT;
                        end else begin
                            r_gap_cnt <= '0;
                            r_state   <= S_POLL_GAP;
                        end
                    end
                end
                S_REPORT: begin
                    if (done_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_reqrsp_offloader.sv
// tb/tb_hwpe_ctrl_reqrsp_offloader.sv - randomized bench with register-target model
module tb_hwpe_ctrl_reqrsp_offloader;

    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int NMAX = 16;
    localparam int PG   = 4;
    localparam int NW   = $clog2(NMAX + 1);
    localparam int SW   = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          clear_i = 1'b0;
    logic          job_valid_i = 1'b0;
    logic          job_ready_o;
    logic [NW-1:0] job_nargs_i = '0;
    logic          job_wait_i = 1'b0;
    logic          arg_valid_i;
    logic          arg_ready_o;
    logic [DW-1:0] arg_data_i;
    logic [AW-1:0] q_addr_o;
    logic          q_write_o;
    logic [DW-1:0] q_data_o;
    logic [SW-1:0] q_strb_o;
    logic          q_valid_o;
    logic          q_ready_i;
    logic [DW-1:0] p_data_i;
    logic          p_valid_i;
    logic          p_ready_o;
    logic          done_valid_o;
    logic          done_ready_i = 1'b0;
    logic [7:0]    done_jobid_o;
    logic          busy_o;

    hwpe_ctrl_reqrsp_offloader #(
        .AW(AW), .DW(DW), .N_ARGS_MAX(NMAX), .POLL_GAP(PG)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_nargs_i(job_nargs_i), .job_wait_i(job_wait_i),
        .arg_valid_i(arg_valid_i), .arg_ready_o(arg_ready_o), .arg_data_i(arg_data_i),
        .q_addr_o(q_addr_o), .q_write_o(q_write_o), .q_data_o(q_data_o),
        .q_strb_o(q_strb_o), .q_valid_o(q_valid_o), .q_ready_i(q_ready_i),
        .p_data_i(p_data_i), .p_valid_i(p_valid_i), .p_ready_o(p_ready_o),
        .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
        .done_jobid_o(done_jobid_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [AW-1:0] a, input logic w,
                                          input logic [SW-1:0] s, input logic [DW-1:0] d);
        return 128'({a, w, s, d});
    endfunction

    // Shared model state: expected transaction order, target register contents
    logic [127:0]  exp_q[$];
    logic [DW-1:0] status_q[$];
    logic [DW-1:0] arg_q[$];
    logic [DW-1:0] pre_l[$];
    logic [DW-1:0] post_l[$];
    logic [7:0]    jobid_val = 8'h00;
    bit            long_push = 1'b0;
    bit            arg_gap3 = 1'b0;
    bit            trig_seen = 1'b0;
    logic [AW-1:0] last_hs_addr = '0;

    // Register target: random accept delays, random response latency, stray strobes
    initial begin
        int            wait_cnt;
        int            idle;
        int            resp_dly;
        bit            hold;
        bit            pend;
        bit            after_hs;
        bit            prev_nz;
        logic [127:0]  saved;
        logic [127:0]  cur;
        logic [127:0]  expv;
        logic [DW-1:0] resp;
        wait_cnt = 0; idle = 0; resp_dly = 0;
        hold = 0; pend = 0; after_hs = 0; prev_nz = 0;
        saved = '0; resp = '0;
        q_ready_i = 1'b0; p_valid_i = 1'b0; p_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i || clear_i) begin
                hold = 0; pend = 0; after_hs = 0; prev_nz = 0; idle = 0;
                q_ready_i = 1'b0; p_valid_i = 1'b0;
            end else begin
                if (pend && p_valid_i) begin
                    pend = 0;
                    p_valid_i = 1'b0;
                end
                check("p_ready", 128'(p_ready_o), 128'(pend));
                if (pend) begin
                    if (resp_dly > 0) resp_dly--;
                    else begin
                        p_valid_i = 1'b1;
                        p_data_i  = resp;
                    end
                end else begin
                    p_valid_i = ($urandom_range(0, 3) == 0);
                    p_data_i  = {$urandom, $urandom};
                end
                if (after_hs) begin
                    check("q_valid_drop", 128'(q_valid_o), 128'(0));
                    after_hs = 0;
                end
                if (!q_valid_o) begin
                    idle++;
                    hold = 0;
                    q_ready_i = 1'($urandom_range(0, 1));
                end else begin
                    cur = pack(q_addr_o, q_write_o, q_strb_o, q_data_o);
                    if (hold) check("q_stable", cur, saved);
                    else begin
                        saved = cur;
                        hold  = 1;
                        if (long_push && q_addr_o == 32'h20) begin
                            wait_cnt  = 7;
                            long_push = 0;
                        end else begin
                            wait_cnt = int'($urandom_range(0, 3));
                        end
                    end
                    if (wait_cnt > 0) begin
                        wait_cnt--;
                        q_ready_i = 1'b0;
                    end else begin
                        q_ready_i = 1'b1;
                        hold      = 0;
                        after_hs  = 1;
                        expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                        check("txn", cur, expv);
                        if (q_addr_o == 32'h08 && !q_write_o && prev_nz)
                            check("repoll_gap", 128'(idle >= PG), 128'(1));
                        idle = 0;
                        last_hs_addr = q_addr_o;
                        if (q_write_o && q_addr_o == 32'h00) trig_seen = 1;
                        prev_nz = 0;
                        if (!q_write_o) begin
                            pend      = 1;
                            p_valid_i = 1'b0;
                            resp_dly  = int'($urandom_range(0, 2));
                            if (q_addr_o == 32'h08) begin
                                resp    = (status_q.size() > 0) ? status_q.pop_front() : '0;
                                prev_nz = (resp != '0);
                            end else begin
                                resp      = {$urandom, $urandom};
                                resp[7:0] = jobid_val;
                            end
                        end
                    end
                end
            end
        end
    end

    // Argument source with random (or forced 3-cycle) gaps
    initial begin
        int gap;
        bit took;
        gap = 0; took = 0;
        arg_valid_i = 1'b0; arg_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i || clear_i) begin
                arg_valid_i = 1'b0; took = 0; gap = 0;
            end else begin
                if (took) begin
                    if (arg_q.size() > 0) arg_q.delete(0);
                    arg_valid_i = 1'b0;
                    gap = arg_gap3 ? 3 : int'($urandom_range(0, 2));
                end
                if (!arg_valid_i) begin
                    if (gap > 0) gap--;
                    else if (arg_q.size() > 0) begin
                        arg_valid_i = 1'b1;
                        arg_data_i  = arg_q[0];
                    end
                end
                took = arg_valid_i && arg_ready_o;
            end
        end
    end

    task automatic do_reset(input bit use_clear);
        if (use_clear) clear_i = 1'b1;
        else rst_i = 1'b1;
        job_valid_i  = 1'b0;
        done_ready_i = 1'b0;
        @(negedge clk_i);
        check("rst_ctrl", 128'({q_valid_o, p_ready_o, arg_ready_o, done_valid_o, busy_o, job_ready_o}),
              128'(6'b000001));
        check("rst_q", 128'({q_addr_o, q_write_o, q_strb_o, q_data_o}), 128'(0));
        check("rst_jobid", 128'(done_jobid_o), 128'(0));
        exp_q.delete(); status_q.delete(); arg_q.delete();
        trig_seen = 0; long_push = 0; last_hs_addr = '0;
        @(negedge clk_i);
        rst_i = 1'b0; clear_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("post_rst_idle", 128'({q_valid_o, busy_o}), 128'(0));
        end
    endtask

    // mode: 0 normal, 1 reset once polling after trigger, 2 clear on a PUSH request
    task automatic run_job(input int nargs_in, input bit wt, input logic [7:0] jid,
                           input int dhold, input int mode);
        int            n;
        int            t;
        bit            aborted;
        logic [DW-1:0] a;
        n = (nargs_in > NMAX) ? NMAX : nargs_in;
        exp_q.delete(); status_q.delete();
        foreach (pre_l[i]) begin
            status_q.push_back(pre_l[i]);
            exp_q.push_back(pack(32'h08, 1'b0, '0, '0));
        end
        for (int i = 0; i < n; i++) begin
            a = {$urandom, $urandom};
            arg_q.push_back(a);
            exp_q.push_back(pack(32'h20, 1'b1, '1, a));
        end
        exp_q.push_back(pack(32'h00, 1'b1, '1, '0));
        exp_q.push_back(pack(32'h10, 1'b0, '0, '0));
        if (wt) begin
            foreach (post_l[i]) begin
                status_q.push_back(post_l[i]);
                exp_q.push_back(pack(32'h08, 1'b0, '0, '0));
            end
        end
        jobid_val = jid;
        trig_seen = 0;
        t = 0;
        while (!job_ready_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        check("job_ready", 128'(job_ready_o), 128'(1));
        job_valid_i = 1'b1;
        job_nargs_i = NW'(nargs_in);
        job_wait_i  = wt;
        @(negedge clk_i);
        job_valid_i = 1'b0;
        check("busy_after_accept", 128'({busy_o, job_ready_o}), 128'(2'b10));
        t = 0;
        aborted = 0;
        while (!done_valid_o && t < 5000 && !aborted) begin
            @(negedge clk_i);
            t++;
            if (mode == 1 && p_ready_o && trig_seen && last_hs_addr == 32'h08) begin
                do_reset(1'b0);
                aborted = 1;
            end else if (mode == 2 && q_valid_o && q_write_o && q_addr_o == 32'h20) begin
                do_reset(1'b1);
                aborted = 1;
            end
        end
        if (aborted) return;
        check("done_valid", 128'(done_valid_o), 128'(1));
        if (!done_valid_o) begin
            do_reset(1'b0);
            return;
        end
        check("done_jobid", 128'(done_jobid_o), 128'(jid));
        check("txns_left", 128'(exp_q.size()), 128'(0));
        for (int k = 0; k < dhold; k++) begin
            @(negedge clk_i);
            check("done_hold", 128'({done_valid_o, done_jobid_o}), 128'({1'b1, jid}));
        end
        done_ready_i = 1'b1;
        @(negedge clk_i);
        done_ready_i = 1'b0;
        check("report_exit", 128'({done_valid_o, busy_o, job_ready_o}), 128'(3'b001));
    endtask

    task automatic fill_list(input bit post, input int nz);
        if (post) post_l.delete();
        else pre_l.delete();
        for (int i = 0; i < nz; i++) begin
            if (post) post_l.push_back(DW'($urandom_range(1, 255)));
            else pre_l.push_back(DW'($urandom_range(1, 255)));
        end
        if (post) post_l.push_back('0);
        else pre_l.push_back('0);
    endtask

    initial begin
        @(negedge clk_i);
        do_reset(1'b0);

        // three arguments, no wait, JOBID 0x05
        fill_list(0, 0); fill_list(1, 0);
        run_job(3, 1'b0, 8'h05, 1, 0);

        // no arguments, busy STATUS twice before trigger and once after
        pre_l = '{64'd1, 64'd1, 64'd0};
        post_l = '{64'd1, 64'd0};
        run_job(0, 1'b1, 8'hA7, 2, 0);

        // PUSH request stalled for 7 cycles
        long_push = 1;
        fill_list(0, 0);
        run_job(2, 1'b0, 8'h3C, 0, 0);

        // 3-cycle argument gaps, completion held 5 cycles
        arg_gap3 = 1;
        fill_list(0, 1);
        run_job(4, 1'b0, 8'h81, 5, 0);
        arg_gap3 = 0;

        // reset while polling, clear on a PUSH, then a normal job
        fill_list(0, 0);
        post_l = '{64'd1, 64'd1, 64'd1, 64'd0};
        run_job(1, 1'b1, 8'h11, 0, 1);
        fill_list(0, 0);
        run_job(3, 1'b0, 8'h22, 0, 2);
        fill_list(0, 1); fill_list(1, 1);
        run_job(2, 1'b1, 8'h33, 1, 0);

        // argument count boundaries and saturation
        fill_list(0, 0);
        run_job(NMAX, 1'b0, 8'h44, 0, 0);
        run_job(20, 1'b0, 8'h55, 0, 0);
        run_job((1 << NW) - 1, 1'b1, 8'h66, 1, 0);

        for (int j = 0; j < 15; j++) begin
            fill_list(0, int'($urandom_range(0, 2)));
            fill_list(1, int'($urandom_range(0, 2)));
            run_job(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
                    8'($urandom), int'($urandom_range(0, 3)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hwpe_ctrl_reqrsp_offloader.md
HWPE_CTRL_REQRSP_OFFLOADER -- requirements
Module: hwpe_ctrl_reqrsp_offloader

Interface
REQ-001 SHALL have parameter AW, default 32, reqrsp address width.
REQ-002 SHALL have parameter DW, default 64, reqrsp data width.
REQ-003 SHALL have parameter N_ARGS_MAX, default 16, maximum arguments pushed per job; NW = $clog2(N_ARGS_MAX+1).
REQ-004 SHALL have parameter POLL_GAP, default 4, idle cycles between consecutive STATUS polls (>=1).
REQ-005 clk_i  in  1  single clock, rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 clear_i  in  1  synchronous soft clear, same effect as rst_i.
REQ-008 job_valid_i / job_ready_o  in/out  1/1  job command handshake.
REQ-009 job_nargs_i  in  NW  number of arguments to PUSH (0..N_ARGS_MAX).
REQ-010 job_wait_i  in  1  1 = poll STATUS until the job completes before reporting.
REQ-011 arg_valid_i / arg_ready_o / arg_data_i  in/out/in  1/1/DW  argument stream.
REQ-012 q_addr_o, q_write_o, q_data_o, q_strb_o, q_valid_o  out  AW,1,DW,DW/8,1  reqrsp request to hwpe_ctrl_reqrsp_target.
REQ-013 q_ready_i  in  1  request accepted.
REQ-014 p_data_i / p_valid_i / p_ready_o  in/in/out  DW/1/1  read response.
REQ-015 done_valid_o / done_ready_i / done_jobid_o  out/in/out  1/1/8  completion report.
REQ-016 busy_o  out  1  high in every state except IDLE.

Function
REQ-017 Register byte addresses SHALL be index<<3: TRIGGER 0x00, STATUS 0x08, JOBID 0x10, PUSH 0x20; upper address bits zero.
REQ-018 Exactly one reqrsp transaction outstanding; q_* SHALL be registered and held stable from q_valid_o rise until the q_valid_o&&q_ready_i cycle, q_valid_o low the following cycle.
REQ-019 Writes: q_write_o=1, q_strb_o all ones, no response phase awaited. Reads: q_write_o=0, q_strb_o=0, q_data_o=0; p_ready_o high only in *_RSP states; data captured on p_valid_i&&p_ready_o.
REQ-020 States: IDLE, ACQ_REQ, ACQ_RSP, ACQ_GAP, PUSH_ARG, PUSH_REQ, TRIG_REQ, JOBID_REQ, JOBID_RSP, POLL_GAP, POLL_REQ, POLL_RSP, REPORT.
REQ-021 IDLE: job_ready_o=1; on job_valid_i latch nargs (saturated at N_ARGS_MAX) and wait flag -> ACQ_REQ.
REQ-022 ACQ_REQ reads STATUS; ACQ_RSP: p_data_i==0 -> PUSH_ARG (or TRIG_REQ if nargs==0), else -> ACQ_GAP, waiting POLL_GAP cycles -> ACQ_REQ.
REQ-023 PUSH_ARG: arg_ready_o=1; accepted arg_data_i registered -> PUSH_REQ (write PUSH); on accept decrement counter; counter 0 -> TRIG_REQ else -> PUSH_ARG. arg_ready_o=0 in all other states.
REQ-024 TRIG_REQ writes 0 to TRIGGER -> JOBID_REQ; JOBID_RSP captures p_data_i[7:0] into done_jobid_o register -> POLL_GAP if wait flag, else REPORT.
REQ-025 POLL_GAP waits POLL_GAP cycles -> POLL_REQ (read STATUS); POLL_RSP: p_data_i==0 -> REPORT, else -> POLL_GAP.
REQ-026 REPORT: done_valid_o=1, held with done_jobid_o stable until done_ready_i; -> IDLE the same cycle. Next job accepted at earliest one cycle later.
REQ-027 p_valid_i outside *_RSP states SHALL be ignored; q_ready_i while q_valid_o=0 SHALL be ignored.
REQ-028 Gap counter and argument counter SHALL never wrap; nargs > N_ARGS_MAX saturates.

Reset
REQ-029 On rst_i or clear_i (sampled at rising edge), next cycle: state IDLE, q_valid_o=0, p_ready_o=0, arg_ready_o=0, done_valid_o=0, busy_o=0, job_ready_o=1, q_addr_o=0, q_data_o=0, q_strb_o=0, q_write_o=0, done_jobid_o=0, counters 0.
REQ-030 Reset/clear mid-transaction SHALL abort immediately; no request reissued; pending responses dropped.

Verification
REQ-031 Job nargs=3, wait=0, STATUS=0, JOBID returns 0x05 -> reads 0x08, writes 0x20 x3 with args in order, write 0x00 data 0, read 0x10; done_jobid_o=0x05.
REQ-032 nargs=0, wait=1, STATUS returns 1,1,0 before trigger and 1,0 after -> no PUSH writes; each re-poll preceded by >=4 idle cycles; done_valid_o after final 0.
REQ-033 q_ready_i held low 7 cycles on a PUSH -> q_addr_o/q_data_o/q_valid_o unchanged for all 7 cycles, single acceptance.
REQ-034 arg_valid_i gaps of 3 cycles and done_ready_i low 5 cycles -> no spurious writes; done_valid_o and done_jobid_o stable 5 cycles.
REQ-035 rst_i asserted during POLL_RSP, then clear_i during PUSH_REQ of a second job -> all outputs at REQ-029 values next cycle; third job completes normally.
